// File: rtl/pc_opponent.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_opponent: computer player (think, pick/scan a free cell, fire) plus   |
// | the per-second countdown for the human player's turn.                    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pc_opponent #(
  parameter int         CLK_HZ       = 50_000_000,
  parameter int         TURN_SECONDS = 10,
  parameter int         THINK_CYCLES = 25_000_000,
  parameter logic [2:0] ST_PLAYER    = 3'd2,
  parameter logic [2:0] ST_PC        = 3'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic [2:0] rand_row,
  input  logic [2:0] rand_col,
  output logic       fire_pc,
  output logic [2:0] shot_row,
  output logic [2:0] shot_col,
  output logic       pc_mov,
  output logic       time_expired,
  output logic [3:0] seconds_left
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TW = (THINK_CYCLES > 1) ? $clog2(THINK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);
  localparam logic [TW-1:0] THINK_LAST = TW'(THINK_CYCLES - 1);
  localparam logic [3:0]    TURN_LOAD  = 4'(TURN_SECONDS);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_THINK = 3'd1;
  localparam logic [2:0] S_PICK  = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_FIRE  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]    fsm;
  logic [2:0]    prev_state;
  logic [TW-1:0] think_cnt;
  logic [PW-1:0] presc;
  logic [2:0]    cand_row;
  logic [2:0]    cand_col;
  logic [24:0]   shot_map;

  logic [2:0] pick_row, pick_col, next_row, next_col;
  logic       in_pc, pc_entry, player_entry;

  function automatic logic [4:0] cell_idx(input logic [2:0] r, input logic [2:0] c);
    return 5'(r) * 5'd5 + 5'(c);
  endfunction

  assign in_pc        = (state == ST_PC);
  assign pc_entry     = in_pc && (prev_state != ST_PC);
  assign player_entry = (state == ST_PLAYER) && (prev_state != ST_PLAYER);

  // Random inputs span 0..7 but the board is 5x5; fold 5..7 back onto 0..2.
  assign pick_row = (rand_row > 3'd4) ? rand_row - 3'd5 : rand_row;
  assign pick_col = (rand_col > 3'd4) ? rand_col - 3'd5 : rand_col;

  always_comb begin
    next_row = cand_row;
    next_col = cand_col + 3'd1;
    if (cand_col == 3'd4) begin
      next_col = 3'd0;
      next_row = (cand_row == 3'd4) ? 3'd0 : cand_row + 3'd1;
    end
  end

  assign fire_pc = (fsm == S_FIRE);
  assign pc_mov  = (fsm == S_DONE);

  // Reset value of ST_PC keeps a turn from starting on release if the game FSM is already in ST_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_state <= ST_PC;
    else        prev_state <= state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      think_cnt <= '0;
      cand_row  <= 3'd0;
      cand_col  <= 3'd0;
      shot_row  <= 3'd0;
      shot_col  <= 3'd0;
      shot_map  <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (pc_entry) begin
            fsm       <= S_THINK;
            think_cnt <= '0;
          end
        end
        S_THINK: begin
          if (!in_pc) begin
            fsm       <= S_IDLE;
            think_cnt <= '0;
          end else if (think_cnt == THINK_LAST) begin
            fsm       <= S_PICK;
            think_cnt <= '0;
          end else begin
            think_cnt <= think_cnt + TW'(1);
          end
        end
        S_PICK: begin
          if (!in_pc) begin
            fsm <= S_IDLE;
          end else if (&shot_map) begin
            fsm <= S_DONE;
          end else if (!shot_map[cell_idx(pick_row, pick_col)]) begin
            shot_row <= pick_row;
            shot_col <= pick_col;
            fsm      <= S_FIRE;
          end else begin
            cand_row <= pick_row;
            cand_col <= pick_col;
            fsm      <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Terminates: the map cannot be full here, and it only changes in FIRE.
          if (!in_pc) begin
            fsm <= S_IDLE;
          end else if (!shot_map[cell_idx(next_row, next_col)]) begin
            shot_row <= next_row;
            shot_col <= next_col;
            fsm      <= S_FIRE;
          end else begin
            cand_row <= next_row;
            cand_col <= next_col;
          end
        end
        S_FIRE: begin
          shot_map[cell_idx(shot_row, shot_col)] <= 1'b1;
          fsm <= S_DONE;
        end
        S_DONE:  fsm <= S_IDLE;
        default: fsm <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seconds_left <= TURN_LOAD;
      presc        <= '0;
      time_expired <= 1'b0;
    end else begin
      time_expired <= 1'b0;
      if (player_entry) begin
        seconds_left <= TURN_LOAD;
        presc        <= '0;
      end else if ((state == ST_PLAYER) && (seconds_left != 4'd0)) begin
        if (presc == PRESC_LAST) begin
          presc        <= '0;
          seconds_left <= seconds_left - 4'd1;
          if (seconds_left == 4'd1) time_expired <= 1'b1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_opponent.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pc_opponent: directed self-checking bench for pc_opponent.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pc_opponent;

  localparam logic [2:0] ST_PLAYER = 3'd2;
  localparam logic [2:0] ST_PC     = 3'd3;
  localparam logic [2:0] ST_OTHER  = 3'd0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state, rand_row, rand_col;
  logic       fire_pc, pc_mov, time_expired;
  logic [2:0] shot_row, shot_col;
  logic [3:0] seconds_left;

  int checks = 0;
  int errors = 0;

  int         fire_cnt, fire_cyc, mov_cnt, mov_cyc;
  logic [2:0] f_row, f_col;

  pc_opponent #(
    .CLK_HZ(4), .TURN_SECONDS(2), .THINK_CYCLES(3), .ST_PLAYER(ST_PLAYER), .ST_PC(ST_PC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .rand_row(rand_row), .rand_col(rand_col),
    .fire_pc(fire_pc), .shot_row(shot_row), .shot_col(shot_col), .pc_mov(pc_mov),
    .time_expired(time_expired), .seconds_left(seconds_left)
  );

  always #5 clk = ~clk;

  // Leaves ST_PC for one cycle, re-enters it, and records strobes over a bounded window.
  task automatic run_turn(input logic [2:0] r, input logic [2:0] c);
    @(negedge clk) state = ST_OTHER;
    @(negedge clk) begin state = ST_PC; rand_row = r; rand_col = c; end
    fire_cnt = 0; fire_cyc = -1; mov_cnt = 0; mov_cyc = -1; f_row = 3'd7; f_col = 3'd7;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (fire_pc === 1'b1) begin
        fire_cnt++;
        if (fire_cyc < 0) begin fire_cyc = i; f_row = shot_row; f_col = shot_col; end
      end
      if (pc_mov === 1'b1) begin
        mov_cnt++;
        if (mov_cyc < 0) mov_cyc = i;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (fire_pc !== 1'b0) begin errors++; $display("FAIL reset_fire got=%b exp=0", fire_pc); end
    checks++; if (pc_mov !== 1'b0) begin errors++; $display("FAIL reset_mov got=%b exp=0", pc_mov); end
    checks++; if (time_expired !== 1'b0) begin errors++; $display("FAIL reset_exp got=%b exp=0", time_expired); end
    checks++; if ({shot_row, shot_col} !== 6'd0) begin errors++; $display("FAIL reset_shot got=%0d,%0d exp=0,0", shot_row, shot_col); end
    checks++; if (seconds_left !== 4'd2) begin errors++; $display("FAIL reset_sec got=%0d exp=2", seconds_left); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (fire_pc !== 1'b0 || pc_mov !== 1'b0 || seconds_left !== 4'd2) begin
      errors++; $display("FAIL reset_release got=%b%b,%0d exp=00,2", fire_pc, pc_mov, seconds_left);
    end
  endtask

  task automatic test_first_shot;
    run_turn(3'd2, 3'd3);
    checks++; if (fire_cnt !== 1) begin errors++; $display("FAIL first_fire_cnt got=%0d exp=1", fire_cnt); end
    checks++; if (fire_cyc !== 5) begin errors++; $display("FAIL first_fire_cyc got=%0d exp=5", fire_cyc); end
    checks++; if (f_row !== 3'd2 || f_col !== 3'd3) begin errors++; $display("FAIL first_shot got=%0d,%0d exp=2,3", f_row, f_col); end
    checks++; if (mov_cnt !== 1 || mov_cyc !== 6) begin errors++; $display("FAIL first_mov got=%0d@%0d exp=1@6", mov_cnt, mov_cyc); end
    checks++; if (shot_row !== 3'd2 || shot_col !== 3'd3) begin errors++; $display("FAIL first_hold got=%0d,%0d exp=2,3", shot_row, shot_col); end
  endtask

  task automatic test_scan;
    run_turn(3'd7, 3'd3);
    checks++; if (fire_cnt !== 1 || fire_cyc !== 6) begin errors++; $display("FAIL scan_fire got=%0d@%0d exp=1@6", fire_cnt, fire_cyc); end
    checks++; if (f_row !== 3'd2 || f_col !== 3'd4) begin errors++; $display("FAIL scan_shot got=%0d,%0d exp=2,4", f_row, f_col); end
    checks++; if (mov_cnt !== 1 || mov_cyc !== 7) begin errors++; $display("FAIL scan_mov got=%0d@%0d exp=1@7", mov_cnt, mov_cyc); end
  endtask

  task automatic test_abort_think;
    int nf, nm;
    nf = 0; nm = 0;
    @(negedge clk) state = ST_OTHER;
    @(negedge clk) begin state = ST_PC; rand_row = 3'd3; rand_col = 3'd3; end
    repeat (2) @(posedge clk);
    @(negedge clk) state = ST_OTHER;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (fire_pc === 1'b1) nf++;
      if (pc_mov === 1'b1) nm++;
    end
    checks++; if (nf !== 0) begin errors++; $display("FAIL abort_fire got=%0d exp=0", nf); end
    checks++; if (nm !== 0) begin errors++; $display("FAIL abort_mov got=%0d exp=0", nm); end
  endtask

  task automatic test_timer;
    logic [3:0] es;
    @(negedge clk) state = ST_PLAYER;
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk); #1;
      es = (i < 5) ? 4'd2 : (i < 9) ? 4'd1 : 4'd0;
      checks++; if (seconds_left !== es) begin errors++; $display("FAIL timer_sec cyc=%0d got=%0d exp=%0d", i, seconds_left, es); end
      checks++; if (time_expired !== (i == 9)) begin errors++; $display("FAIL timer_exp cyc=%0d got=%b exp=%b", i, time_expired, (i == 9)); end
    end
    @(negedge clk) state = ST_OTHER;
    repeat (5) @(posedge clk); #1;
    checks++; if (seconds_left !== 4'd0) begin errors++; $display("FAIL timer_hold0 got=%0d exp=0", seconds_left); end
    @(negedge clk) state = ST_PLAYER;
    repeat (2) @(posedge clk); #1;
    checks++; if (seconds_left !== 4'd2) begin errors++; $display("FAIL timer_reload got=%0d exp=2", seconds_left); end
    @(negedge clk) state = ST_OTHER;
    repeat (8) @(posedge clk); #1;
    checks++; if (seconds_left !== 4'd2 || time_expired !== 1'b0) begin
      errors++; $display("FAIL timer_freeze got=%0d,%b exp=2,0", seconds_left, time_expired);
    end
  endtask

  task automatic test_fill_wrap_full;
    for (int c = 1; c <= 24; c++) begin
      if (c != 13 && c != 14) begin
        run_turn(3'(c / 5), 3'(c % 5));
        checks++; if (fire_cnt !== 1 || fire_cyc !== 5 || f_row !== 3'(c / 5) || f_col !== 3'(c % 5) || mov_cnt !== 1) begin
          errors++; $display("FAIL fill_cell%0d got=%0d@%0d (%0d,%0d) mov=%0d exp=1@5 (%0d,%0d) mov=1",
                             c, fire_cnt, fire_cyc, f_row, f_col, mov_cnt, c / 5, c % 5);
        end
      end
    end
    run_turn(3'd4, 3'd4);
    checks++; if (fire_cnt !== 1 || fire_cyc !== 6) begin errors++; $display("FAIL wrap_fire got=%0d@%0d exp=1@6", fire_cnt, fire_cyc); end
    checks++; if (f_row !== 3'd0 || f_col !== 3'd0) begin errors++; $display("FAIL wrap_shot got=%0d,%0d exp=0,0", f_row, f_col); end
    run_turn(3'd1, 3'd1);
    checks++; if (fire_cnt !== 0) begin errors++; $display("FAIL full_fire got=%0d exp=0", fire_cnt); end
    checks++; if (mov_cnt !== 1 || mov_cyc !== 5) begin errors++; $display("FAIL full_mov got=%0d@%0d exp=1@5", mov_cnt, mov_cyc); end
    checks++; if (shot_row !== 3'd0 || shot_col !== 3'd0) begin errors++; $display("FAIL full_hold got=%0d,%0d exp=0,0", shot_row, shot_col); end
  endtask

  task automatic test_reset_mid_scan;
    int nf, nm;
    nf = 0; nm = 0;
    @(negedge clk) begin rst_n = 1'b0; state = ST_OTHER; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      run_turn(3'd0, 3'(c));
      checks++; if (fire_cnt !== 1 || fire_cyc !== 5 || f_row !== 3'd0 || f_col !== 3'(c)) begin
        errors++; $display("FAIL cleared_cell%0d got=%0d@%0d (%0d,%0d) exp=1@5 (0,%0d)", c, fire_cnt, fire_cyc, f_row, f_col, c);
      end
    end
    @(negedge clk) state = ST_OTHER;
    @(negedge clk) begin state = ST_PC; rand_row = 3'd0; rand_col = 3'd0; end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (fire_pc === 1'b1) nf++;
      if (pc_mov === 1'b1) nm++;
    end
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++; if (fire_pc !== 1'b0 || pc_mov !== 1'b0) begin errors++; $display("FAIL rstscan_strobe got=%b%b exp=00", fire_pc, pc_mov); end
    checks++; if (shot_row !== 3'd0 || shot_col !== 3'd0 || seconds_left !== 4'd2) begin
      errors++; $display("FAIL rstscan_outs got=%0d,%0d,%0d exp=0,0,2", shot_row, shot_col, seconds_left);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (fire_pc === 1'b1) nf++;
      if (pc_mov === 1'b1) nm++;
    end
    checks++; if (nf !== 0 || nm !== 0) begin errors++; $display("FAIL rstscan_after got=%0d,%0d exp=0,0", nf, nm); end
  endtask

  initial begin
    rst_n = 1'b0; state = ST_OTHER; rand_row = 3'd0; rand_col = 3'd0;
    test_reset();
    test_first_shot();
    test_scan();
    test_abort_think();
    test_timer();
    test_fill_wrap_full();
    test_reset_mid_scan();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
